// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Imported by the byte receiver and the loader top.
package prog_loader_pkg;

  localparam int         DEFAULT_CLKS_PER_BIT = 174;
  localparam logic [7:0] SYNC_BYTE            = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_CHK,
    ST_ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // True while a load owns the processor (the hold window).
  function automatic logic is_loading(ld_state_e s);
    return (s == ST_LEN_H) || (s == ST_LEN_L) || (s == ST_DATA_H) ||
           (s == ST_DATA_L) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with input synchronizer and start-bit glitch rejection.
// Emits a one-cycle byte_valid or frame_err the cycle after the stop-bit sample.
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Line back high at mid start bit: treat the edge as a glitch.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a sync/length/data/checksum frame over UART
// and writes 16-bit words into program RAM while holding the processor.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_en,
  input  logic        rx,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_wren,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .frame_err (rx_ferr)
  );

  ld_state_e   state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] words_q, words_d;
  logic [7:0]  chk_q, chk_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        wren_q, wren_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        hold_q, hold_d;
  logic [15:0] len_n;

  assign len_n = {len_q[15:8], rx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      words_q    <= '0;
      chk_q      <= '0;
      mem_data_q <= '0;
      wren_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      chk_q      <= chk_d;
      mem_data_q <= mem_data_d;
      wren_q     <= wren_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    words_d    = words_q;
    chk_d      = chk_q;
    mem_data_d = mem_data_q;
    wren_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;

    // The address advances only once the write it labelled has been issued.
    if (wren_q) begin
      addr_d  = addr_q + 16'd1;
      words_d = words_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: if (ld_en) state_d = ST_SYNC;
      ST_SYNC: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_LEN_H;
          err_d   = 1'b0;
          words_d = '0;
          addr_d  = '0;
          chk_d   = '0;
        end
      end
      ST_LEN_H: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          state_d     = ST_LEN_L;
        end
      end
      ST_LEN_L: begin
        if (rx_valid) begin
          len_d = len_n;
          if ({1'b0, len_n} > DEPTH_W) state_d = ST_ERR;
          else if (len_n == 16'd0)     state_d = ST_CHK;
          else                         state_d = ST_DATA_H;
        end
      end
      ST_DATA_H: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = ST_DATA_L;
        end
      end
      ST_DATA_L: begin
        if (rx_valid) begin
          wren_d     = 1'b1;
          mem_data_d = {hi_q, rx_data};
          chk_d      = chk_q ^ rx_data;
          state_d    = (addr_q + 16'd1 == len_q) ? ST_CHK : ST_DATA_H;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            done_d  = 1'b1;
            state_d = ST_SYNC;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        err_d   = 1'b1;
        state_d = ST_SYNC;
      end
      default: state_d = ST_IDLE;
    endcase

    if (is_loading(state_q) && rx_ferr) state_d = ST_ERR;

    // Dropping ld_en overrides everything, including a write about to issue.
    if (!ld_en && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      wren_d  = 1'b0;
      done_d  = 1'b0;
      if (is_loading(state_q) || state_q == ST_ERR) err_d = 1'b1;
    end

    hold_d = is_loading(state_d);
  end

  assign mem_addr     = addr_q;
  assign mem_data     = mem_data_q;
  assign mem_wren     = wren_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as frames
// are sent and matched against every mem_wren pulse.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_en = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] mem_addr, mem_data, words_loaded;
  logic        mem_wren, cpu_hold, done, err;

  prog_loader #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_en       (ld_en),
    .rx          (rx),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          wren_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every write must match the oldest outstanding expected {addr, data}.
  always @(negedge clk) begin
    if (mem_wren) begin
      wren_cnt++;
      check("wren_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("wren_addr_data", {mem_addr, mem_data}, exp_q.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic bit_period();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    bit_period();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_period();
    end
    rx = stop_bit;
    bit_period();
    rx = 1'b1;
    bit_period();
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_data"},  32'(mem_data), 32'd0);
    check({tag, "_wren"},  32'(mem_wren), 32'd0);
    check({tag, "_hold"},  32'(cpu_hold), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  int w0, d0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    ld_en = 1'b1;
    repeat (4) @(negedge clk);

    // Good two-word frame
    w0 = wren_cnt; d0 = done_cnt;
    exp_q.push_back({16'd0, 16'h1234});
    exp_q.push_back({16'd1, 16'hABCD});
    send_byte(8'hA5);
    check("f1_hold_after_sync", 32'(cpu_hold), 32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    check("f1_hold_before_chk", 32'(cpu_hold), 32'd1);
    send_byte(8'h40);
    settle();
    check("f1_wrens", 32'(wren_cnt - w0), 32'd2);
    check("f1_done",  32'(done_cnt - d0), 32'd1);
    check("f1_words", 32'(words_loaded), 32'd2);
    check("f1_err",   32'(err), 32'd0);
    check("f1_hold",  32'(cpu_hold), 32'd0);
    check("f1_queue", 32'(exp_q.size()), 32'd0);

    // Same frame, bad checksum
    w0 = wren_cnt; d0 = done_cnt;
    exp_q.push_back({16'd0, 16'h1234});
    exp_q.push_back({16'd1, 16'hABCD});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h41);
    settle();
    check("f2_wrens", 32'(wren_cnt - w0), 32'd2);
    check("f2_done",  32'(done_cnt - d0), 32'd0);
    check("f2_err",   32'(err), 32'd1);
    check("f2_hold",  32'(cpu_hold), 32'd0);
    check("f2_state", 32'(dut.state_q), 32'(ST_SYNC));
    check("f2_queue", 32'(exp_q.size()), 32'd0);

    // Length above DEPTH
    w0 = wren_cnt; d0 = done_cnt;
    send_byte(8'hA5);
    check("f3_err_cleared", 32'(err), 32'd0);
    send_byte(8'h01); send_byte(8'h01);
    settle();
    check("f3_err",   32'(err), 32'd1);
    check("f3_wrens", 32'(wren_cnt - w0), 32'd0);
    check("f3_hold",  32'(cpu_hold), 32'd0);

    // Zero-length frame
    w0 = wren_cnt; d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    settle();
    check("f4_done",  32'(done_cnt - d0), 32'd1);
    check("f4_words", 32'(words_loaded), 32'd0);
    check("f4_wrens", 32'(wren_cnt - w0), 32'd0);
    check("f4_err",   32'(err), 32'd0);

    // Start glitch then framing error inside DATA_H
    w0 = wren_cnt; d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    rx = 1'b0;
    repeat (CPB * 3 / 10) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("f5_glitch_err",  32'(err), 32'd0);
    check("f5_glitch_hold", 32'(cpu_hold), 32'd1);
    check("f5_glitch_state", 32'(dut.state_q), 32'(ST_DATA_H));
    send_byte(8'h12, 1'b0);
    settle();
    check("f5_ferr_err",  32'(err), 32'd1);
    check("f5_ferr_hold", 32'(cpu_hold), 32'd0);
    check("f5_wrens",     32'(wren_cnt - w0), 32'd0);

    // Reset mid-byte, then a clean reload from address 0
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    rx = 1'b0;
    bit_period();
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      bit_period();
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    w0 = wren_cnt; d0 = done_cnt;
    exp_q.push_back({16'd0, 16'hBEEF});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h51);
    settle();
    check("f6_done",  32'(done_cnt - d0), 32'd1);
    check("f6_wrens", 32'(wren_cnt - w0), 32'd1);
    check("f6_words", 32'(words_loaded), 32'd1);
    check("f6_err",   32'(err), 32'd0);
    check("f6_queue", 32'(exp_q.size()), 32'd0);

    // ld_en dropped mid-load
    w0 = wren_cnt; d0 = done_cnt;
    exp_q.push_back({16'd0, 16'h1234});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    check("f7_hold_loading", 32'(cpu_hold), 32'd1);
    ld_en = 1'b0;
    @(negedge clk);
    check("f7_abort_err",  32'(err), 32'd1);
    check("f7_abort_hold", 32'(cpu_hold), 32'd0);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h40);
    settle();
    check("f7_wrens", 32'(wren_cnt - w0), 32'd1);
    check("f7_done",  32'(done_cnt - d0), 32'd0);
    check("f7_words", 32'(words_loaded), 32'd1);
    check("f7_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 174, giving the serial bit period in clk cycles (20 MHz / 115200).
REQ-002 SHALL have parameter DEPTH, default 256, giving the RAM depth in 16-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ld_en, input, 1 bit: loader armed while high.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line, 8N1, idle high.
REQ-007 SHALL have port mem_addr, output, 16 bits: RAM write address.
REQ-008 SHALL have port mem_data, output, 16 bits: RAM write data.
REQ-009 SHALL have port mem_wren, output, 1 bit: RAM write strobe.
REQ-010 SHALL have port cpu_hold, output, 1 bit: holds the processor PC and clock enable while high.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on successful load.
REQ-012 SHALL have port err, output, 1 bit: sticky error flag.
REQ-013 SHALL have port words_loaded, output, 16 bits: count of words written in the current or last load.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Byte receiver SHALL detect a start bit on a synchronized falling edge and re-check rx at CLKS_PER_BIT/2; if rx is high there, it SHALL discard the start as a glitch and return to idle.
REQ-016 Receiver SHALL sample 8 data bits, LSB first, at one-CLKS_PER_BIT intervals from the start-bit midpoint, then sample the stop bit.
REQ-017 Stop bit = 0 SHALL raise a framing error; the byte SHALL be discarded.
REQ-018 Receiver SHALL issue a one-cycle byte_valid with the byte on the cycle after the stop-bit sample.
REQ-019 Loader FSM states SHALL be IDLE, SYNC, LEN_H, LEN_L, DATA_H, DATA_L, CHK, ERR.
REQ-020 IDLE->SYNC SHALL occur when ld_en=1; any state except IDLE SHALL go to IDLE when ld_en=0.
REQ-021 SYNC SHALL ignore every byte except 0xA5; on 0xA5 it SHALL go to LEN_H, set cpu_hold=1, clear err, and zero words_loaded, the address counter and the checksum.
REQ-022 LEN_H then LEN_L SHALL capture word count N, big-endian.
REQ-023 After LEN_L: N > DEPTH SHALL go to ERR with no writes; N = 0 SHALL go to CHK; otherwise the FSM SHALL go to DATA_H.
REQ-024 DATA_H SHALL latch the high byte; DATA_L SHALL latch the low byte.
REQ-025 Exactly one cycle after the DATA_L byte_valid, mem_wren SHALL be 1 for exactly one cycle, with mem_addr = word index (0..N-1) and mem_data = {hi, lo}.
REQ-026 The address counter and words_loaded SHALL increment on the cycle after mem_wren.
REQ-027 After the N-th word the FSM SHALL go to CHK; otherwise it SHALL return to DATA_H.
REQ-028 Checksum SHALL be the 8-bit XOR of all data bytes only; sync and length bytes are excluded.
REQ-029 In CHK, a received byte equal to the checksum SHALL pulse done for one cycle and go to SYNC; a mismatch SHALL go to ERR.
REQ-030 A framing error in any state from LEN_H to CHK SHALL go to ERR; in SYNC it SHALL be ignored.
REQ-031 ERR SHALL set err=1 and go to SYNC on the next cycle.
REQ-032 Words already written before an error SHALL remain written; no rollback.
REQ-033 cpu_hold SHALL be 1 exactly while the FSM is in LEN_H..CHK, and SHALL drop on the cycle after done or entry to ERR.
REQ-034 ld_en falling mid-load SHALL abort to IDLE, set err=1 and drop cpu_hold on the next cycle, with no further writes.
REQ-035 mem_wren SHALL never assert outside DATA_L completion, and SHALL never assert for an address >= N.

Reset
REQ-036 rst_n=0 SHALL immediately set the FSM to IDLE and the receiver to idle.
REQ-037 While rst_n=0, mem_addr=0, mem_data=0, mem_wren=0, cpu_hold=0, done=0, err=0 and words_loaded=0.
REQ-038 Both synchronizer flops SHALL reset to 1 (line idle).
REQ-039 Reset during a load SHALL abandon the load; partial writes SHALL remain in RAM.

Structure
REQ-040 Shared package prog_loader_pkg SHALL hold the loader state enum, SYNC_BYTE = 8'hA5 and the default CLKS_PER_BIT.
REQ-041 The byte receiver SHALL be a separate sub-module uart_rx_byte (ports clk, rst_n, rx, byte_valid, byte_data, frame_err), instantiated once.

Verification
REQ-042 Bench SHALL drive A5 00 02 12 34 AB CD 40 -> required: two wren pulses (addr0 = 0x1234, addr1 = 0xABCD), one done pulse, words_loaded = 2, err = 0, cpu_hold low afterwards.
REQ-043 Bench SHALL drive the same frame with checksum 0x41 -> required: both words written, err = 1, no done, FSM back in SYNC.
REQ-044 Bench SHALL drive A5 01 01 (N = 257 > DEPTH) -> required: err = 1, zero wren pulses.
REQ-045 Bench SHALL drive A5 00 00 00 -> required: done pulse, words_loaded = 0, no wren.
REQ-046 Bench SHALL drive a 0.3-bit low glitch on rx, then a stop bit forced to 0 inside DATA_H -> required: glitch ignored; framing error sets err = 1.
REQ-047 Bench SHALL pulse rst_n low while a word is mid-byte -> required: all outputs 0 at once; the next A5 frame loads correctly from address 0.
